lsu_initiator: RTL and testbench
================================

Name: lsu_initiator

Overview:
Load/store initiator between the execute stage and the word-organised data memory. Accepts one load or store request at a time and converts RISC-V byte addresses and funct3 into word addresses, byte-lane write enables and lane-replicated write data. Receives word read data, then extracts, sign- or zero-extends and returns the result. Fully implements LB/LH/LW/LBU/LHU and SB/SH/SW, and flags misaligned or unsupported accesses without touching memory.

Parameters:
DM_ADDRESS, 9, byte-address width presented to data memory
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  instruction bits 14:12
req_addr  in  32  byte address (ALU result)
req_wdata  in  DATA_W  store data (rs2)
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  DATA_W  formatted load result (0 for stores and errors)
resp_err  out  1  valid with resp_valid: misaligned or unsupported funct3
mem_addr  out  DM_ADDRESS  word-aligned byte address (low 2 bits 0)
mem_re  out  1  read strobe
mem_be  out  4  byte-lane write enables; nonzero means write
mem_wdata  out  DATA_W  lane-replicated write data
mem_rdata  in  DATA_W  word returned one cycle after mem_re

Behaviour:
- Reset (async, reset_n=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_re=0, mem_be=0, mem_addr=0, mem_wdata=0; req_ready=1. Reset mid-operation abandons the access. Strobes drop immediately. No response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on req_valid&&req_ready, register we/funct3/addr/wdata.
  - If the access is legal: go to ISSUE.
  - Otherwise: go to RESP with err=1.
- Legal loads: funct3 000, 100 (any addr); 001, 101 (addr[0]=0); 010 (addr[1:0]=00).
- Legal stores: funct3 000 (any addr); 001 (addr[0]=0); 010 (addr[1:0]=00).
- All other funct3 values are illegal.
- ISSUE (1 cycle): mem_addr = {addr[DM_ADDRESS-1:2],2'b00}. Address bits above DM_ADDRESS are ignored and wrap silently.
  - Load: mem_re=1, mem_be=0; next state WAIT.
  - Store: mem_re=0, mem_be/mem_wdata per the lane rules below; next state RESP.
- WAIT (1 cycle): sample mem_rdata, format it, register the result; next state RESP.
- RESP (1 cycle): resp_valid=1 with the registered rdata/err; next state IDLE. req_ready becomes 1 again the cycle after RESP.
- mem_re and mem_be are nonzero only in ISSUE. Both are registered outputs, so there are no glitches.
- Latency from accept edge to resp_valid:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- Throughput: one request per latency+1 cycles.
- Store lanes, with off = addr[1:0]:
  - SB: be = 4'b0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata = wdata.
- Load extract: lane = mem_rdata >> (8*off).
  - LB: sign-extend lane[7:0].
  - LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0].
  - LHU: zero-extend lane[15:0].
  - LW: mem_rdata.
- req_valid while not in IDLE is ignored. The requester must hold the request until it sees req_ready.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t {IDLE, ISSUE, WAIT, RESP}
  - functions is_legal(we, funct3, off), store_be(funct3, off), load_fmt(funct3, off, word)
- One natural combinational sub-module: lsu_lane_align. It computes be/wdata for stores and the formatted result for loads.
- Top level holds the FSM and the registers.

Test Plan:
- Bench memory model returns data 1 cycle after mem_re.
- Reset: word 0x40 preset to 0x8091A2B3; reset_n low mid-ISSUE -> mem_re falls immediately, no resp_valid, req_ready=1 after release.
- Loads of word 0x40 (0x8091A2B3):
  - LB addr 0x43 -> rdata 0xFFFFFF80
  - LBU 0x41 -> 0x000000A2
  - LH 0x42 -> 0xFFFF8091
  - LHU 0x40 -> 0x0000A2B3
  - LW 0x40 -> 0x8091A2B3
  - each with resp_valid exactly 3 cycles after accept
- Stores with wdata 0xDEADBEEF:
  - SB 0x42 -> be=0100, mem_wdata=0xEFEFEFEF, mem_addr=0x40
  - SH 0x46 -> be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x44
  - SW 0x48 -> be=1111
  - each with resp_valid 2 cycles after accept, resp_rdata=0
- Errors: LW 0x41, SH 0x43 and load funct3 011 -> resp_err=1 one cycle after accept; mem_re=0 and mem_be=0 throughout.
- Back-to-back: req_valid held high for SW 0x10=0x12345678 then LW 0x10 -> second accept only after RESP; load returns 0x12345678; req_ready low during ISSUE/WAIT/RESP.
- Address wrap: LW 0x00000204 with DM_ADDRESS=9 -> mem_addr=0x004.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
// Holds the RISC-V funct3 encodings, the FSM state type, and the
// legality / byte-enable / load-format functions used by the datapath.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  // Unsigned-extend variants exist only for loads; stores reject them.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] funct3,
                                           input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (funct3)
      F3_B:    res = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   res = {24'h0, lane[7:0]};
      F3_H:    res = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   res = {16'h0, lane[15:0]};
      F3_W:    res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_initiator_if.sv
// Request/response and data-memory signal bundle for lsu_initiator.
//   req_*  : request from execute stage (valid/ready handshake)
//   resp_* : one-cycle completion pulse with load data / error flag
//   mem_*  : word-organised data memory port (read data one cycle after mem_re)
// slave  : the initiator's view; master : the environment's view.
interface lsu_initiator_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_re;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_re, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_re, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment.
//   st_* : store side -- byte enables and lane-replicated write data
//   ld_* : load side  -- lane extract with sign/zero extension
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_funct3_i,
  input  logic [1:0]        st_off_i,
  input  logic [DATA_W-1:0] st_wdata_i,
  output logic [3:0]        st_be_o,
  output logic [DATA_W-1:0] st_wdata_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [DATA_W-1:0] ld_data_o
);

  always_comb begin
    st_be_o = store_be(st_funct3_i, st_off_i);
    case (st_funct3_i)
      F3_B:    st_wdata_o = {4{st_wdata_i[7:0]}};
      F3_H:    st_wdata_o = {2{st_wdata_i[15:0]}};
      default: st_wdata_o = st_wdata_i;
    endcase
    ld_data_o = load_fmt(ld_funct3_i, ld_off_i, ld_word_i);
  end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: accepts one request at a time, drives the data
// memory for a single ISSUE cycle, and returns a one-cycle response.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : request, response and data-memory signals
// Latency from accept edge to resp_valid: load 3, store 2, error 1 cycle.
module lsu_initiator
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  lsu_initiator_if.slave  bus
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  mem_re_q, mem_re_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;

  logic [3:0]            st_be;
  logic [DATA_W-1:0]     st_wdata;
  logic [DATA_W-1:0]     ld_data;
  logic                  unused_addr_hi;

  // Byte address bits above the memory width wrap silently.
  assign unused_addr_hi = ^bus.req_addr[31:DM_ADDRESS];

  // Store lanes come straight from the request so the memory strobes can be
  // registered on the accept edge; load formatting uses the captured fields.
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_funct3_i (bus.req_funct3),
    .st_off_i    (bus.req_addr[1:0]),
    .st_wdata_i  (bus.req_wdata),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_word_i   (bus.mem_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    mem_re_d     = 1'b0;
    mem_be_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d  = bus.req_we;
          f3_d  = bus.req_funct3;
          off_d = bus.req_addr[1:0];
          if (is_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            state_d     = ISSUE;
            mem_addr_d  = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
            mem_re_d    = ~bus.req_we;
            mem_be_d    = bus.req_we ? st_be : 4'b0000;
            mem_wdata_d = bus.req_we ? st_wdata : '0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      mem_re_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      mem_re_q     <= mem_re_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_initiator.sv
module tb_lsu_initiator;

  logic clk;
  logic reset_n;

  lsu_initiator_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  lsu_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: read data appears one cycle after mem_re, byte-lane writes.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_be[b]) mem[bus.mem_addr[8:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int lat, input logic [3:0] be,
                              input logic [31:0] mw, input logic [31:0] ma);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
    v.exp_be = be; v.exp_mwdata = mw; v.exp_maddr = ma;
    return v;
  endfunction

  // Issue one request and follow it to its response, recording memory activity.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err,
                         output logic saw_re, output logic saw_be,
                         output logic [3:0] be, output logic [31:0] mw,
                         output logic [31:0] ma);
    int waited;
    lat = 99; rdata = 'x; err = 1'bx;
    saw_re = 1'b0; saw_be = 1'b0; be = '0; mw = '0; ma = '0;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.mem_re) begin saw_re = 1'b1; ma = 32'(bus.mem_addr); end
      if (bus.mem_be != 4'b0000) begin
        saw_be = 1'b1; be = bus.mem_be; mw = bus.mem_wdata; ma = 32'(bus.mem_addr);
      end
      if (bus.resp_valid) begin
        lat = n; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rdata, mw, ma;
    logic err, saw_re, saw_be;
    logic [3:0] be;
    exp_t e;
    logic [6:0] exp_ready;
    logic [6:0] exp_rv;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[16] = 32'h8091A2B3;
    mem[1]  = 32'hCAFEF00D;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0;

    // Reset values
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err",   32'(bus.resp_err), 32'd0);
    check("rst_mem_re",     32'(bus.mem_re), 32'd0);
    check("rst_mem_be",     32'(bus.mem_be), 32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata",  bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted in the middle of ISSUE abandons the load
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("midrst_issue_re", 32'(bus.mem_re), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_re_drop",   32'(bus.mem_re), 32'd0);
    check("midrst_addr_drop", 32'(bus.mem_addr), 32'd0);
    check("midrst_ready",     32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("midrst_no_resp",  32'(bus.resp_valid), 32'd0);
      check("midrst_ready_hi", 32'(bus.req_ready), 32'd1);
    end

    // Vector table
    vecs.push_back(mk(0, 3'b000, 32'h43,  '0, 32'hFFFFFF80, 0, 3, 4'h0, '0, 32'h40)); // LB
    vecs.push_back(mk(0, 3'b100, 32'h41,  '0, 32'h000000A2, 0, 3, 4'h0, '0, 32'h40)); // LBU
    vecs.push_back(mk(0, 3'b001, 32'h42,  '0, 32'hFFFF8091, 0, 3, 4'h0, '0, 32'h40)); // LH
    vecs.push_back(mk(0, 3'b101, 32'h40,  '0, 32'h0000A2B3, 0, 3, 4'h0, '0, 32'h40)); // LHU
    vecs.push_back(mk(0, 3'b010, 32'h40,  '0, 32'h8091A2B3, 0, 3, 4'h0, '0, 32'h40)); // LW
    vecs.push_back(mk(1, 3'b000, 32'h42, 32'hDEADBEEF, '0, 0, 2, 4'b0100, 32'hEFEFEFEF, 32'h40)); // SB
    vecs.push_back(mk(1, 3'b001, 32'h46, 32'hDEADBEEF, '0, 0, 2, 4'b1100, 32'hBEEFBEEF, 32'h44)); // SH
    vecs.push_back(mk(1, 3'b010, 32'h48, 32'hDEADBEEF, '0, 0, 2, 4'b1111, 32'hDEADBEEF, 32'h48)); // SW
    vecs.push_back(mk(0, 3'b010, 32'h40,  '0, 32'h80EFA2B3, 0, 3, 4'h0, '0, 32'h40)); // LW after SB
    vecs.push_back(mk(0, 3'b010, 32'h44,  '0, 32'hBEEF0000, 0, 3, 4'h0, '0, 32'h44)); // LW after SH
    vecs.push_back(mk(0, 3'b101, 32'h46,  '0, 32'h0000BEEF, 0, 3, 4'h0, '0, 32'h44)); // LHU upper
    vecs.push_back(mk(0, 3'b000, 32'h48,  '0, 32'hFFFFFFEF, 0, 3, 4'h0, '0, 32'h48)); // LB after SW
    vecs.push_back(mk(0, 3'b010, 32'h41,  '0, '0, 1, 1, 4'h0, '0, '0)); // LW misaligned
    vecs.push_back(mk(1, 3'b001, 32'h43, 32'h1, '0, 1, 1, 4'h0, '0, '0)); // SH misaligned
    vecs.push_back(mk(0, 3'b011, 32'h40,  '0, '0, 1, 1, 4'h0, '0, '0)); // load f3 011
    vecs.push_back(mk(1, 3'b100, 32'h40, 32'h1, '0, 1, 1, 4'h0, '0, '0)); // store f3 100
    vecs.push_back(mk(0, 3'b010, 32'h204, '0, 32'hCAFEF00D, 0, 3, 4'h0, '0, 32'h004)); // wrap

    foreach (vecs[i]) begin
      e.rdata = vecs[i].exp_rdata;
      e.err   = vecs[i].exp_err;
      sb_q.push_back(e);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              lat, rdata, err, saw_re, saw_be, be, mw, ma);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (lat != 99 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_rdata", i), rdata, e.rdata);
        check($sformatf("v%0d_err", i), 32'(err), 32'(e.err));
      end else begin
        sb_q.delete();
      end
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_no_mem_re", i), 32'(saw_re), 32'd0);
        check($sformatf("v%0d_no_mem_be", i), 32'(saw_be), 32'd0);
      end else if (vecs[i].we) begin
        check($sformatf("v%0d_be", i), 32'(be), 32'(vecs[i].exp_be));
        check($sformatf("v%0d_mem_wdata", i), mw, vecs[i].exp_mwdata);
        check($sformatf("v%0d_mem_addr", i), ma, vecs[i].exp_maddr);
        check($sformatf("v%0d_no_mem_re", i), 32'(saw_re), 32'd0);
      end else begin
        check($sformatf("v%0d_mem_addr", i), ma, vecs[i].exp_maddr);
        check($sformatf("v%0d_no_mem_be", i), 32'(saw_be), 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d_resp_pulse", i), 32'(bus.resp_valid), 32'd0);
    end

    // Back-to-back with req_valid held: SW 0x10 then LW 0x10
    e.rdata = 32'h0;        e.err = 1'b0; sb_q.push_back(e);
    e.rdata = 32'h12345678; e.err = 1'b0; sb_q.push_back(e);
    exp_ready = 7'b1000100;  // bit n-1 for cycle n after first accept
    exp_rv    = 7'b0100010;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = '0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d_ready", n), 32'(bus.req_ready), 32'(exp_ready[n-1]));
      check($sformatf("b2b_c%0d_resp_valid", n), 32'(bus.resp_valid), 32'(exp_rv[n-1]));
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("b2b_unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("b2b_c%0d_rdata", n), bus.resp_rdata, e.rdata);
          check($sformatf("b2b_c%0d_err", n), 32'(bus.resp_err), 32'(e.err));
        end
      end
      if (n == 4) bus.req_valid = 1'b0;
    end
    check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
    check("b2b_mem_word", mem[4], 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
